// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: valid/ready byte FIFO drained by an 8N1 framer onto txd.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1 frames).
module uart_tx_buffered #(
  parameter int unsigned CLK_FREQUENCY = 12_000_000,
  parameter int unsigned BAUD          = 115_200,
  parameter int unsigned FIFO_DEPTH    = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          txd,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned ClksPerBit = CLK_FREQUENCY / BAUD;
  localparam int unsigned CntW       = (ClksPerBit > 1) ? $clog2(ClksPerBit) : 1;
  localparam int unsigned AddrW      = $clog2(FIFO_DEPTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(ClksPerBit - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AddrW:0]  wr_ptr_q, rd_ptr_q;
  logic            full, empty, push, pop, bit_done;
  logic [7:0]      head;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;
  logic            txd_q;
  logic            busy_q;
`ifdef UART_TX_PARITY_EN
  logic            parity_q;
`endif

  // Extra pointer MSB distinguishes full from empty when the addresses match.
  assign full       = (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]) &&
                      (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]);
  assign empty      = (wr_ptr_q == rd_ptr_q);
  assign tx_ready   = !full;
  assign push       = tx_valid && !full;
  assign fifo_count = wr_ptr_q - rd_ptr_q;
  assign head       = mem[rd_ptr_q[AddrW-1:0]];
  assign bit_done   = (cnt_q == LastCnt);

  // Pop from idle, or on the last stop-bit cycle so frames run back to back.
  assign pop = !empty && ((state_q == StIdle) || ((state_q == StStop) && bit_done));

  assign txd  = txd_q;
  assign busy = busy_q;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[AddrW-1:0]] <= tx_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (pop) begin
            shift_q <= head;
`ifdef UART_TX_PARITY_EN
            parity_q <= ^head;
`endif
            txd_q   <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StStart;
          end
        end
        StStart: begin
          if (bit_done) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            txd_q     <= shift_q[0];
            state_q   <= StData;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StData: begin
          if (bit_done) begin
            cnt_q <= '0;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              txd_q   <= parity_q;
              state_q <= StParity;
`else
              txd_q   <= 1'b1;
              state_q <= StStop;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              shift_q   <= shift_q >> 1;
              txd_q     <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        StParity: begin
          if (bit_done) begin
            cnt_q   <= '0;
            txd_q   <= 1'b1;
            state_q <= StStop;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif
        StStop: begin
          if (bit_done) begin
            cnt_q <= '0;
            if (pop) begin
              shift_q <= head;
`ifdef UART_TX_PARITY_EN
              parity_q <= ^head;
`endif
              txd_q   <= 1'b0;
              state_q <= StStart;
            end else begin
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          txd_q   <= 1'b1;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule
